// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: grants one requester,
// drives its operands, captures the result and pulses that requester's done.
// Define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 always wins contention).
module alu_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             op0,
  input  logic             op1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cf,
  input  logic             alu_gtz,
  output logic [WIDTH-1:0] res_out,
  output logic             cf_out,
  output logic             gtz_out,
  output logic             done0,
  output logic             done1,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t state;
  logic   served;
  logic   grant1;

`ifdef ALU_ARB_FIXED_PRI_EN
  assign grant1 = req1 & ~req0;
`else
  logic last_served;

  // On contention the requester that was not served last time wins.
  assign grant1 = req1 & (~req0 | ~last_served);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_served <= 1'b1;
    end else if (state == IDLE && (req0 || req1)) begin
      last_served <= grant1;
    end
  end
`endif

  // Operands are frozen at grant; done is issued from CAPTURE so it is visible in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      served  <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= 1'b0;
      res_out <= '0;
      cf_out  <= 1'b0;
      gtz_out <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            served <= grant1;
            alu_a  <= grant1 ? a1 : a0;
            alu_b  <= grant1 ? b1 : b0;
            alu_op <= grant1 ? op1 : op0;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          res_out <= alu_result;
          cf_out  <= alu_cf;
          gtz_out <= alu_gtz;
          done0   <= ~served;
          done1   <= served;
          state   <= DONE;
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_alu_arbiter;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         op0 = 1'b0, op1 = 1'b0;
  logic [W-1:0] alu_a, alu_b, alu_result, res_out;
  logic         alu_op, alu_cf, alu_gtz, cf_out, gtz_out, done0, done1, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: op 1 adds with carry out, op 0 is OR with the AND bits cleared.
  function automatic logic [W+1:0] aluRef(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    logic [W:0]   sum;
    logic [W-1:0] r;
    logic         c;
    if (op) begin
      sum = {1'b0, a} + {1'b0, b};
      r   = sum[W-1:0];
      c   = sum[W];
    end else begin
      r = (a | b) & ~(a & b);
      c = 1'b0;
    end
    return {c, (r != '0), r};
  endfunction

  assign {alu_cf, alu_gtz, alu_result} = aluRef(alu_a, alu_b, alu_op);

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .op0(op0), .op1(op1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cf(alu_cf), .alu_gtz(alu_gtz),
    .res_out(res_out), .cf_out(cf_out), .gtz_out(gtz_out),
    .done0(done0), .done1(done1), .busy(busy)
  );

  // Model state: an operation in flight and how many edges have passed since its grant.
  bit           inFlight = 0;
  int           age = 0;
  bit           winner = 0;
  bit           lastServed = 1;
  logic [W+1:0] pend = '0;
  logic [W-1:0] expAluA = '0, expAluB = '0, expRes = '0;
  logic         expAluOp = 0, expCf = 0, expGtz = 0, expDone0 = 0, expDone1 = 0, expBusy = 0;

  // Advance the model by one rising edge, using the inputs the DUT saw at that edge.
  function automatic void stepModel();
    if (!reset) begin
      inFlight = 0; age = 0; lastServed = 1;
      expAluA = '0; expAluB = '0; expAluOp = 0;
      expRes = '0; expCf = 0; expGtz = 0;
      expDone0 = 0; expDone1 = 0; expBusy = 0;
    end else if (inFlight) begin
      age++;
      if (age == 2) begin
        {expCf, expGtz, expRes} = pend;
        expDone0 = !winner;
        expDone1 = winner;
      end else if (age == 3) begin
        inFlight = 0;
        expDone0 = 0; expDone1 = 0; expBusy = 0;
      end
    end else if (req0 || req1) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      winner = !req0;
`else
      winner = (req0 && req1) ? !lastServed : req1;
`endif
      lastServed = winner;
      expAluA  = winner ? a1 : a0;
      expAluB  = winner ? b1 : b0;
      expAluOp = winner ? op1 : op0;
      pend     = aluRef(expAluA, expAluB, expAluOp);
      inFlight = 1; age = 0; expBusy = 1;
    end
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("alu_a", 32'(alu_a), 32'(expAluA));
    checkVal("alu_b", 32'(alu_b), 32'(expAluB));
    checkVal("alu_op", 32'(alu_op), 32'(expAluOp));
    checkVal("res_out", 32'(res_out), 32'(expRes));
    checkVal("cf_out", 32'(cf_out), 32'(expCf));
    checkVal("gtz_out", 32'(gtz_out), 32'(expGtz));
    checkVal("done0", 32'(done0), 32'(expDone0));
    checkVal("done1", 32'(done1), 32'(expDone1));
    checkVal("busy", 32'(busy), 32'(expBusy));
    checkVal("done_exclusive", 32'(done0 & done1), 32'd0);
  endtask

  task automatic tick();
    @(negedge clk);
    stepModel();
    checkOutput();
  endtask

  task automatic applyStimulus(input logic r0, input logic [W-1:0] x0, input logic [W-1:0] y0, input logic o0,
                               input logic r1, input logic [W-1:0] x1, input logic [W-1:0] y1, input logic o1);
    req0 = r0; a0 = x0; b0 = y0; op0 = o0;
    req1 = r1; a1 = x1; b1 = y1; op1 = o1;
  endtask

  initial begin
    tick();
    checkVal("rst_alu_a", 32'(alu_a), 32'd0);
    checkVal("rst_res_out", 32'(res_out), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_done0", 32'(done0), 32'd0);
    reset = 1'b1;
    tick();

    // Logic op, then operand change during ISSUE must not disturb the latched values.
    applyStimulus(1, 5'b10101, 5'b11011, 0, 0, '0, '0, 0);
    tick();
    checkVal("issue_alu_a", 32'(alu_a), 32'b10101);
    checkVal("issue_alu_b", 32'(alu_b), 32'b11011);
    checkVal("issue_busy", 32'(busy), 32'd1);
    a0 = 5'b00000;
    tick();
    checkVal("latched_alu_a", 32'(alu_a), 32'b10101);
    tick();
    checkVal("logic_done0", 32'(done0), 32'd1);
    checkVal("logic_done1", 32'(done1), 32'd0);
    checkVal("logic_res", 32'(res_out), 32'b01110);
    checkVal("logic_gtz", 32'(gtz_out), 32'd1);
    req0 = 1'b0;
    tick();
    checkVal("after_done0", 32'(done0), 32'd0);

    // Add on requester 1.
    applyStimulus(0, '0, '0, 0, 1, 5'b01101, 5'b00011, 1);
    tick(); tick(); tick();
    checkVal("add_done1", 32'(done1), 32'd1);
    checkVal("add_res", 32'(res_out), 32'b10000);
    checkVal("add_cf", 32'(cf_out), 32'd0);
    checkVal("add_gtz", 32'(gtz_out), 32'd1);
    req1 = 1'b0;
    tick();

    // Wrapping add, then the captured values must hold while idle.
    applyStimulus(1, 5'b11111, 5'b00001, 1, 0, '0, '0, 0);
    tick(); tick(); tick();
    checkVal("wrap_res", 32'(res_out), 32'd0);
    checkVal("wrap_cf", 32'(cf_out), 32'd1);
    checkVal("wrap_gtz", 32'(gtz_out), 32'd0);
    req0 = 1'b0;
    tick(); tick(); tick();
    checkVal("hold_res", 32'(res_out), 32'd0);
    checkVal("hold_cf", 32'(cf_out), 32'd1);

    // Continuous contention straight after reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    applyStimulus(1, 5'd3, 5'd4, 1, 1, 5'd5, 5'd6, 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i % 4 == 3) begin
`ifdef ALU_ARB_FIXED_PRI_EN
        checkVal("contend_done0", 32'(done0), 32'd1);
        checkVal("contend_done1", 32'(done1), 32'd0);
`else
        checkVal("contend_done0", 32'(done0), 32'(((i / 4) % 2) == 0));
        checkVal("contend_done1", 32'(done1), 32'(((i / 4) % 2) == 1));
`endif
      end
    end
    applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
    tick();

    // Reset during CAPTURE aborts the operation without a done pulse.
    applyStimulus(1, 5'd9, 5'd2, 1, 0, '0, '0, 0);
    tick(); tick();
    checkVal("cap_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    req0 = 1'b0;
    #1;
    checkVal("abort_busy", 32'(busy), 32'd0);
    checkVal("abort_res", 32'(res_out), 32'd0);
    checkVal("abort_alu_a", 32'(alu_a), 32'd0);
    checkVal("abort_done0", 32'(done0), 32'd0);
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    checkVal("post_abort_done0", 32'(done0), 32'd0);
    checkVal("post_abort_busy", 32'(busy), 32'd0);

    // Random traffic: requesters hold req until their done, sometimes re-requesting at once.
    for (int c = 0; c < 800; c++) begin
      tick();
      reset = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      if (req0 && expDone0 && $urandom_range(0, 3) != 0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 2) == 0) req0 = 1'b1;
      if (req1 && expDone1 && $urandom_range(0, 3) != 0) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 2) == 0) req1 = 1'b1;
      a0 = W'($urandom); b0 = W'($urandom); op0 = 1'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); op1 = 1'($urandom);
    end
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
